// File: rtl/wdg_rst_ctrl_if.sv
// Request/status bundle between the reset controller and its surroundings.
// The controller takes the slave side; the watchdog/software side is the master.
interface wdg_rst_ctrl_if;
  logic       wdg_rst_req_i;
  logic       sw_rst_req_i;
  logic       cause_clr_i;
  logic       sys_rst_n_o;
  logic       rst_busy_o;
  logic [2:0] rst_cause_o;
  logic [7:0] wdg_rst_cnt_o;

  modport master (
    output wdg_rst_req_i, sw_rst_req_i, cause_clr_i,
    input  sys_rst_n_o, rst_busy_o, rst_cause_o, wdg_rst_cnt_o
  );

  modport slave (
    input  wdg_rst_req_i, sw_rst_req_i, cause_clr_i,
    output sys_rst_n_o, rst_busy_o, rst_cause_o, wdg_rst_cnt_o
  );
endinterface

// File: rtl/wdg_rst_ctrl.sv
// Always-on reset controller: stretches watchdog/software reset requests into a
// registered system reset pulse and keeps a reset-cause record across it.
module wdg_rst_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 16,
  parameter int HOLD_CYCLES  = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  wdg_rst_ctrl_if.slave bus
);

  localparam logic [1:0] ST_ASSERT = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   busy_q, busy_d;
  logic [2:0]             cause_q, cause_d;
  logic [7:0]             wcnt_q, wcnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   wdg_sync;
  logic                   trigger;

  // The watchdog request is asynchronous; only the last synchroniser stage is used.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.wdg_rst_req_i};
  assign wdg_sync = sync_q[SYNC_STAGES-1];
  assign trigger  = wdg_sync | bus.sw_rst_req_i;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    sys_rst_n_d = sys_rst_n_q;
    busy_d      = busy_q;
    cause_d     = cause_q;
    wcnt_d      = wcnt_q;

    case (state_q)
      ST_ASSERT: begin
        sys_rst_n_d = 1'b0;
        busy_d      = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          state_d     = ST_HOLD;
          cnt_d       = '0;
          sys_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // Requests arriving here are dropped, which keeps back-to-back resets spaced.
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_IDLE: begin
        if (trigger) begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          sys_rst_n_d = 1'b0;
          busy_d      = 1'b1;
          cause_d     = {bus.sw_rst_req_i, wdg_sync, 1'b0};
          if (wdg_sync && (wcnt_q != 8'hFF)) wcnt_d = wcnt_q + 8'd1;
        end else if (bus.cause_clr_i) begin
          cause_d = '0;
          wcnt_d  = '0;
        end
      end

      default: begin
        state_d     = ST_ASSERT;
        cnt_d       = '0;
        sys_rst_n_d = 1'b0;
        busy_d      = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the synchroniser is reset too, so a stale request cannot fire right after POR.
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      sys_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
      cause_q     <= 3'b001;
      wcnt_q      <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_rst_n_q <= sys_rst_n_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
      wcnt_q      <= wcnt_d;
      sync_q      <= sync_d;
    end
  end

  assign bus.sys_rst_n_o   = sys_rst_n_q;
  assign bus.rst_busy_o    = busy_q;
  assign bus.rst_cause_o   = cause_q;
  assign bus.wdg_rst_cnt_o = wcnt_q;

endmodule

// File: tb/tb_wdg_rst_ctrl.sv
// Directed bench for wdg_rst_ctrl: expected output snapshots are queued as each
// step is driven and popped for comparison once the DUT has clocked.
module tb_wdg_rst_ctrl;

  logic clk_i = 1'b0;
  logic rst_n_i;

  wdg_rst_ctrl_if bus ();

  wdg_rst_ctrl #(
    .SYNC_STAGES (2),
    .PULSE_CYCLES(16),
    .HOLD_CYCLES (8)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic       sys;
    logic       busy;
    logic [2:0] cause;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic s, input logic b,
                          input logic [2:0] c, input logic [7:0] n);
    exp_t e;
    e.tag = tag; e.sys = s; e.busy = b; e.cause = c; e.cnt = n;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".sys_rst_n"}, {7'b0, bus.sys_rst_n_o}, {7'b0, e.sys});
      chk({e.tag, ".busy"},      {7'b0, bus.rst_busy_o},  {7'b0, e.busy});
      chk({e.tag, ".cause"},     {5'b0, bus.rst_cause_o}, {5'b0, e.cause});
      chk({e.tag, ".wdg_cnt"},   bus.wdg_rst_cnt_o,       e.cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_run(input string tag, input int n, input logic s, input logic b,
                         input logic [2:0] c, input logic [7:0] cnt);
    for (int i = 0; i < n; i++) begin
      push_exp(tag, s, b, c, cnt);
      tick();
      check_out();
    end
  endtask

  // Trigger edge, 15 further low cycles, 8 hold cycles, then one idle sample.
  task automatic full_pulse(input string tag, input logic [2:0] c, input logic [7:0] cnt,
                            input bit drop_wdg);
    push_exp({tag, "_trig"}, 1'b0, 1'b1, c, cnt);
    tick();
    check_out();
    bus.sw_rst_req_i = 1'b0;
    bus.cause_clr_i  = 1'b0;
    if (drop_wdg) bus.wdg_rst_req_i = 1'b0;
    exp_run({tag, "_low"},  15, 1'b0, 1'b1, c, cnt);
    exp_run({tag, "_hold"},  8, 1'b1, 1'b1, c, cnt);
    exp_run({tag, "_idle"},  1, 1'b1, 1'b0, c, cnt);
  endtask

  initial begin
    rst_n_i           = 1'b1;
    bus.wdg_rst_req_i = 1'b0;
    bus.sw_rst_req_i  = 1'b0;
    bus.cause_clr_i   = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    push_exp("por_reset", 1'b0, 1'b1, 3'b001, 8'd0);
    check_out();
    exp_run("por_in_reset", 2, 1'b0, 1'b1, 3'b001, 8'd0);
    rst_n_i = 1'b1;
    exp_run("por_low",  15, 1'b0, 1'b1, 3'b001, 8'd0);
    exp_run("por_hold",  8, 1'b1, 1'b1, 3'b001, 8'd0);
    exp_run("por_idle",  2, 1'b1, 1'b0, 3'b001, 8'd0);

    // Watchdog request sampled at edges k..k+2; ASSERT entered at k+2.
    bus.wdg_rst_req_i = 1'b1;
    exp_run("wdg_lat", 2, 1'b1, 1'b0, 3'b001, 8'd0);
    full_pulse("wdg", 3'b010, 8'd1, 1'b1);

    // sw pulse on the edge where wdg_sync first reads 1, then a sw pulse in HOLD.
    bus.wdg_rst_req_i = 1'b1;
    exp_run("sim_lat", 2, 1'b1, 1'b0, 3'b010, 8'd1);
    bus.sw_rst_req_i = 1'b1;
    push_exp("sim_trig", 1'b0, 1'b1, 3'b110, 8'd2);
    tick();
    check_out();
    bus.sw_rst_req_i  = 1'b0;
    bus.wdg_rst_req_i = 1'b0;
    exp_run("sim_low",  15, 1'b0, 1'b1, 3'b110, 8'd2);
    exp_run("sim_hold",  2, 1'b1, 1'b1, 3'b110, 8'd2);
    bus.sw_rst_req_i = 1'b1;
    exp_run("hold_sw",   1, 1'b1, 1'b1, 3'b110, 8'd2);
    bus.sw_rst_req_i = 1'b0;
    exp_run("hold_rest", 5, 1'b1, 1'b1, 3'b110, 8'd2);
    exp_run("hold_idle", 3, 1'b1, 1'b0, 3'b110, 8'd2);

    bus.cause_clr_i = 1'b1;
    exp_run("clr", 1, 1'b1, 1'b0, 3'b000, 8'd0);
    bus.cause_clr_i = 1'b0;
    exp_run("clr_idle", 1, 1'b1, 1'b0, 3'b000, 8'd0);

    // Trigger beats a coincident clear.
    bus.sw_rst_req_i = 1'b1;
    bus.cause_clr_i  = 1'b1;
    full_pulse("swclr", 3'b100, 8'd0, 1'b0);

    // Stuck watchdog: back-to-back pulses with a 25-cycle period.
    bus.wdg_rst_req_i = 1'b1;
    exp_run("stk_lat", 2, 1'b1, 1'b0, 3'b100, 8'd0);
    full_pulse("stk1", 3'b010, 8'd1, 1'b0);
    full_pulse("stk2", 3'b010, 8'd2, 1'b0);
    full_pulse("stk3", 3'b010, 8'd3, 1'b0);
    full_pulse("stk4", 3'b010, 8'd4, 1'b1);

    // Watchdog trigger with coincident clear: count goes up from its old value.
    bus.wdg_rst_req_i = 1'b1;
    exp_run("wclr_lat", 2, 1'b1, 1'b0, 3'b010, 8'd4);
    bus.cause_clr_i = 1'b1;
    full_pulse("wclr", 3'b010, 8'd5, 1'b1);

    bus.cause_clr_i = 1'b1;
    exp_run("clr2", 1, 1'b1, 1'b0, 3'b000, 8'd0);
    bus.cause_clr_i = 1'b0;

    // 260+ watchdog events saturate the counter at 255.
    bus.wdg_rst_req_i = 1'b1;
    repeat (2 + 260 * 25) tick();
    bus.wdg_rst_req_i = 1'b0;
    repeat (60) tick();
    exp_run("sat", 1, 1'b1, 1'b0, 3'b010, 8'hFF);

    // Power-on reset dropped in the middle of an ASSERT pulse.
    bus.sw_rst_req_i = 1'b1;
    push_exp("mid_trig", 1'b0, 1'b1, 3'b100, 8'hFF);
    tick();
    check_out();
    bus.sw_rst_req_i = 1'b0;
    exp_run("mid_asrt", 4, 1'b0, 1'b1, 3'b100, 8'hFF);
    #2 rst_n_i = 1'b0;
    #1;
    push_exp("mid_reset", 1'b0, 1'b1, 3'b001, 8'd0);
    check_out();
    exp_run("mid_in_reset", 2, 1'b0, 1'b1, 3'b001, 8'd0);
    rst_n_i = 1'b1;
    exp_run("mid_low",  15, 1'b0, 1'b1, 3'b001, 8'd0);
    exp_run("mid_hold",  8, 1'b1, 1'b1, 3'b001, 8'd0);
    exp_run("mid_idle",  2, 1'b1, 1'b0, 3'b001, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
